// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and defaults for the sequence-detector family
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    localparam int   SEQ_WIDTH    = 8;
    localparam int   SEQ_DEPTH    = 4;
    localparam logic SEQ_IDLE_BIT = 1'b0;

endpackage

// File: rtl/seq_word_fifo.sv
// rtl/seq_word_fifo.sv - synchronous DEPTH x WIDTH word FIFO with level
module seq_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // Pointer next-state: flush discards everything, including a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/seq_word_serializer.sv
// rtl/seq_word_serializer.sv - buffered MSB-first word-to-bit serializer
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH    = SEQ_WIDTH,
    parameter int   DEPTH    = SEQ_DEPTH,
    parameter logic IDLE_BIT = SEQ_IDLE_BIT
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         in_ready_o,
    output logic                         ser_bit_o,
    output logic                         ser_active_o,
    output logic                         word_start_o,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    shift_state_e     state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             start_q, start_d;

    logic             fifo_full, fifo_empty, push, pop;
    logic [WIDTH-1:0] fifo_rdata;

    // Ready ignores any same-cycle pop, so a full FIFO never takes a push.
    assign in_ready_o = !fifo_full && !flush_i && rst_ni;
    assign push       = in_valid_i && in_ready_o;

    seq_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .wdata_i (in_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // Shifter FSM: load from FIFO when idle or on the last bit, else shift left.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        pop     = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        cnt_d   = CW'(WIDTH - 1);
                        start_d = 1'b1;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = fifo_rdata;
                            cnt_d   = CW'(WIDTH - 1);
                            start_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shift_d = {shift_q[WIDTH-2:0], 1'b0};
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
        end
    end

    assign ser_active_o = (state_q == ST_SHIFT);
    assign ser_bit_o    = ser_active_o ? shift_q[WIDTH-1] : IDLE_BIT;
    assign word_start_o = start_q;

endmodule

// File: tb/tb_seq_word_serializer.sv
// tb/tb_seq_word_serializer.sv - directed self-checking bench for seq_word_serializer
module tb_seq_word_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_flush, a_valid, a_ready, a_bit, a_active, a_start;
    logic [7:0] a_data;
    logic [2:0] a_level;

    logic       b_rst_n, b_flush, b_valid, b_ready, b_bit, b_active, b_start;
    logic [3:0] b_data;
    logic [1:0] b_level;

    seq_word_serializer #(.WIDTH(8), .DEPTH(4), .IDLE_BIT(1'b0)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .flush_i(a_flush), .in_valid_i(a_valid),
        .in_data_i(a_data), .in_ready_o(a_ready), .ser_bit_o(a_bit),
        .ser_active_o(a_active), .word_start_o(a_start), .fifo_level_o(a_level)
    );

    seq_word_serializer #(.WIDTH(4), .DEPTH(2), .IDLE_BIT(1'b1)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .flush_i(b_flush), .in_valid_i(b_valid),
        .in_data_i(b_data), .in_ready_o(b_ready), .ser_bit_o(b_bit),
        .ser_active_o(b_active), .word_start_o(b_start), .fifo_level_o(b_level)
    );

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       exp_ready;
        logic       exp_bit;
        logic       exp_active;
        logic       exp_start;
        int         exp_level;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                                input logic b, input logic a, input logic s, input int l);
        vec_t t;
        t.valid = v; t.data = d; t.exp_ready = r; t.exp_bit = b;
        t.exp_active = a; t.exp_start = s; t.exp_level = l;
        return t;
    endfunction

    vec_t       tbl [12];
    logic [7:0] w4 [4];
    logic [7:0] w6 [6];
    logic [3:0] bw [4];
    logic [31:0] s32;
    logic [47:0] s48;
    logic [15:0] s16;
    logic [7:0]  k99;
    logic [7:0]  k81;
    int          lvl_exp [5];
    bit          q [$];
    int          idx, acc_edge5, acc_edge3, first_act, last_act, starts, bad;
    logic        acc;

    initial begin
        k99 = 8'h99;
        k81 = 8'h81;
        // Single word 0x99: accept at E0, MSB after E1, eight bits, then idle.
        tbl[0]  = mk(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 8; i++)
            tbl[2+i] = mk(1'b0, 8'h00, 1'b1, k99[7-i], 1'b1, (i == 0), 0);
        tbl[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        tbl[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        w4 = '{8'hA5, 8'h0F, 8'hFF, 8'h00};
        w6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        bw = '{4'hA, 4'h0, 4'hF, 4'h5};
        s32 = {8'hA5, 8'h0F, 8'hFF, 8'h00};
        s48 = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        s16 = 16'hA0F5;
        lvl_exp = '{1, 1, 2, 3, 4};

        a_rst_n = 1'b0; a_flush = 1'b0; a_valid = 1'b0; a_data = '0;
        b_rst_n = 1'b0; b_flush = 1'b0; b_valid = 1'b0; b_data = '0;
        #2;
        check("rst_ready", a_ready, 0);
        check("rst_active", a_active, 0);
        check("rst_bit", a_bit, 0);
        check("rst_start", a_start, 0);
        check("rst_level", a_level, 0);
        check("b_rst_bit_idle1", b_bit, 1);
        cyc(); cyc();
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        check("ready_after_release", a_ready, 1);
        cyc();

        // Table-driven single word.
        for (int i = 0; i < 12; i++) begin
            a_valid = tbl[i].valid; a_data = tbl[i].data;
            #1;
            check($sformatf("t%0d_ready", i), a_ready, tbl[i].exp_ready);
            check($sformatf("t%0d_bit", i), a_bit, tbl[i].exp_bit);
            check($sformatf("t%0d_active", i), a_active, tbl[i].exp_active);
            check($sformatf("t%0d_start", i), a_start, tbl[i].exp_start);
            check($sformatf("t%0d_level", i), a_level, tbl[i].exp_level);
            cyc();
        end

        // Four words back-to-back: 32 gapless bits, start every 8th.
        for (int c = 0; c < 36; c++) begin
            a_valid = (c < 4); a_data = (c < 4) ? w4[c] : 8'h00;
            #1;
            if (c >= 2 && c < 34) begin
                check($sformatf("burst_bit%0d", c - 2), a_bit, s32[31-(c-2)]);
                check($sformatf("burst_act%0d", c - 2), a_active, 1);
                check($sformatf("burst_start%0d", c - 2), a_start, ((c - 2) % 8 == 0));
            end else begin
                check($sformatf("burst_idle%0d", c), a_active, 0);
                check($sformatf("burst_idlebit%0d", c), a_bit, 0);
            end
            cyc();
        end

        // Six words with in_valid held: level ramp, backpressure, no loss.
        idx = 0; acc_edge5 = -1; first_act = -1; last_act = -1;
        for (int c = 0; c < 60; c++) begin
            a_valid = (idx < 6); a_data = (idx < 6) ? w6[idx] : 8'h00;
            #1;
            if (a_active) begin
                q.push_back(a_bit);
                if (first_act < 0) first_act = c;
                last_act = c;
            end
            acc = a_valid && a_ready;
            cyc();
            if (acc) begin
                if (idx == 5) acc_edge5 = c;
                idx++;
            end
            if (c < 5) check($sformatf("ramp_level%0d", c), a_level, lvl_exp[c]);
            if (c == 4) check("ramp_full_ready", a_ready, 0);
        end
        check("ramp_all_accepted", idx, 6);
        check("ramp_sixth_edge", acc_edge5, 10);
        check("ramp_bits", q.size(), 48);
        check("ramp_gapless", last_act - first_act + 1, 48);
        bad = 0;
        for (int i = 0; i < 48 && i < q.size(); i++)
            if (q[i] != s48[47-i]) bad++;
        check("ramp_stream_errs", bad, 0);
        a_valid = 1'b0;
        cyc();

        // Flush on the 3rd bit of 0xF0 with two words queued and a push pending.
        for (int c = 0; c < 3; c++) begin
            a_valid = 1'b1;
            a_data = (c == 0) ? 8'hF0 : ((c == 1) ? 8'h33 : 8'hCC);
            cyc();
        end
        a_valid = 1'b0;
        #1;
        check("flush_queued", a_level, 2);
        cyc();
        a_flush = 1'b1; a_valid = 1'b1; a_data = 8'h55;
        #1;
        check("flush_third_bit", a_bit, 1);
        check("flush_ready_low", a_ready, 0);
        cyc();
        a_flush = 1'b0; a_valid = 1'b0;
        #1;
        check("flush_bit", a_bit, 0);
        check("flush_active", a_active, 0);
        check("flush_level", a_level, 0);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (a_active || a_level != 0) bad++;
        end
        check("flush_discarded", bad, 0);

        // Asynchronous reset mid-word, then 0x81.
        a_valid = 1'b1; a_data = 8'h3C; cyc();
        a_data = 8'h5A; cyc();
        a_valid = 1'b0; cyc(); cyc();
        #3;
        a_rst_n = 1'b0;
        #1;
        check("arst_bit", a_bit, 0);
        check("arst_active", a_active, 0);
        check("arst_start", a_start, 0);
        check("arst_level", a_level, 0);
        check("arst_ready", a_ready, 0);
        cyc();
        a_rst_n = 1'b1;
        for (int c = 0; c < 11; c++) begin
            a_valid = (c == 0); a_data = 8'h81;
            #1;
            if (c >= 2 && c < 10) begin
                check($sformatf("post_rst_bit%0d", c - 2), a_bit, k81[7-(c-2)]);
                check($sformatf("post_rst_start%0d", c - 2), a_start, (c == 2));
            end else if (c == 10) begin
                check("post_rst_idle", a_active, 0);
            end
            cyc();
        end

        // WIDTH=4, DEPTH=2, IDLE_BIT=1: single word 0x9.
        for (int c = 0; c < 7; c++) begin
            b_valid = (c == 0); b_data = 4'h9;
            #1;
            if (c >= 2 && c < 6) begin
                check($sformatf("b_single_bit%0d", c - 2), b_bit, (c == 2 || c == 5));
                check($sformatf("b_single_act%0d", c - 2), b_active, 1);
                check($sformatf("b_single_start%0d", c - 2), b_start, (c == 2));
            end else begin
                check($sformatf("b_idle_fill%0d", c), b_bit, 1);
                check($sformatf("b_idle_act%0d", c), b_active, 0);
            end
            cyc();
        end

        // WIDTH=4 burst of four words with in_valid held.
        q.delete();
        idx = 0; acc_edge3 = -1; first_act = -1; last_act = -1; starts = 0;
        for (int c = 0; c < 26; c++) begin
            b_valid = (idx < 4); b_data = (idx < 4) ? bw[idx] : 4'h0;
            #1;
            if (b_active) begin
                q.push_back(b_bit);
                if (b_start) starts++;
                if (first_act < 0) first_act = c;
                last_act = c;
            end
            acc = b_valid && b_ready;
            cyc();
            if (acc) begin
                if (idx == 3) acc_edge3 = c;
                idx++;
            end
            if (c == 2) begin
                check("b_three_accepts", idx, 3);
                check("b_full_ready", b_ready, 0);
                check("b_full_level", b_level, 2);
            end
        end
        check("b_fourth_edge", acc_edge3, 6);
        check("b_bits", q.size(), 16);
        check("b_gapless", last_act - first_act + 1, 16);
        check("b_starts", starts, 4);
        bad = 0;
        for (int i = 0; i < 16 && i < q.size(); i++)
            if (q[i] != s16[15-i]) bad++;
        check("b_stream_errs", bad, 0);
        b_valid = 1'b0;
        #1;
        check("b_final_idle_bit", b_bit, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
